// File: rtl/input_conditioner.sv
// Two-channel input conditioner: 2-flop synchronizer, counter-based debounce,
// registered debounced levels with one-cycle rise/fall pulses and a busy flag.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise,
  output logic a_fall,
  output logic b_fall,
  output logic busy
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [NCH-1:0]            raw;
  logic [NCH-1:0]            s1_q, s2_q;
  logic [NCH-1:0]            lvl_q, lvl_d;
  logic [NCH-1:0]            rise_q, rise_d;
  logic [NCH-1:0]            fall_q, fall_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e [NCH-1:0]          state_q, state_d;
  logic                      busy_q, busy_d;

  assign raw = {b_raw, a_raw};

  // Per-channel debounce FSM; pulses fire on the cycle after the level flips.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      unique case (state_q[i])
        ST_STABLE: begin
          if (s2_q[i] != lvl_q[i]) begin
            if (DEBOUNCE_CYCLES > 1) begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_W'(1);
            end else begin
              lvl_d[i] = s2_q[i];
              cnt_d[i] = '0;
            end
          end
        end
        ST_PENDING: begin
          if (s2_q[i] == lvl_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            lvl_d[i]   = s2_q[i];
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
      rise_d[i] = lvl_d[i] & ~lvl_q[i];
      fall_d[i] = ~lvl_d[i] & lvl_q[i];
      busy_d    = busy_d | (state_d[i] == ST_PENDING);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      state_q <= {NCH{ST_STABLE}};
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign a      = lvl_q[0];
  assign b      = lvl_q[1];
  assign a_rise = rise_q[0];
  assign b_rise = rise_q[1];
  assign a_fall = fall_q[0];
  assign b_fall = fall_q[1];
  assign busy   = busy_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive clock cycles a synchronized input must differ from its debounced value before the debounced value changes; legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, width of each per-channel debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_raw  input  1  asynchronous, possibly bouncing input, channel A.
REQ-006 b_raw  input  1  asynchronous, possibly bouncing input, channel B.
REQ-007 a  output  1  debounced level of channel A; drives input a of the downstream sequential circuit.
REQ-008 b  output  1  debounced level of channel B; drives input b of the downstream sequential circuit.
REQ-009 a_rise, b_rise  output  1 each  one-cycle pulse when the debounced level goes 0->1.
REQ-010 a_fall, b_fall  output  1 each  one-cycle pulse when the debounced level goes 1->0.
REQ-011 busy  output  1  high while either channel is in state PENDING.

Function
REQ-012 Each channel SHALL have an identical, independent path: 2-flop synchronizer (s1, s2), debounce counter cnt[CNT_W-1:0], registered debounced level q, registered pulse flops.
REQ-013 Synchronizer: s1 <= raw, s2 <= s1 on every rising edge; no logic between s1 and s2.
REQ-014 Per-channel FSM with two states: STABLE (s2 == q, cnt == 0) and PENDING (s2 != q).
REQ-015 STABLE: if s2 != q and DEBOUNCE_CYCLES > 1 -> PENDING, cnt <= 1; if s2 != q and DEBOUNCE_CYCLES == 1 -> q <= s2, stay STABLE, cnt <= 0.
REQ-016 PENDING: if s2 == q (bounce back) -> STABLE, cnt <= 0, q unchanged, no pulse.
REQ-017 PENDING: if s2 != q and cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
REQ-018 PENDING: if s2 != q and cnt == DEBOUNCE_CYCLES-1 -> q <= s2, cnt <= 0, -> STABLE.
REQ-019 Latency: raw held constant from before edge E0, first edge sampling the new value; q changes at edge E(DEBOUNCE_CYCLES+1).
REQ-020 rise/fall SHALL be registered and asserted for exactly the one cycle following the edge at which q changes; rise iff new q = 1, fall iff new q = 0; never both in the same cycle.
REQ-021 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 busy SHALL be the OR of the two channels' PENDING state, registered in step with state.
REQ-023 Channels A and B changing simultaneously SHALL be debounced independently; both may update q and pulse in the same cycle.
REQ-024 Pulse-shorter-than-debounce: any raw excursion whose s2 image lasts fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on q and no pulse.

Reset
REQ-025 While reset is high at a rising edge: s1, s2, q, cnt, all rise/fall flops, busy <= 0; both FSMs -> STABLE.
REQ-026 Reset asserted mid-PENDING SHALL abort the count; no pulse SHALL be generated for the aborted transition.
REQ-027 After reset deasserts with raw = 1, the channel SHALL treat it as a new 0->1 transition, q rising at E(DEBOUNCE_CYCLES+1) with a rise pulse.
REQ-028 Reset has priority over all other updates.

Verification (DEBOUNCE_CYCLES = 4, clock period 160 ns)
REQ-029 Reset 2 cycles, a_raw=b_raw=0 -> a=b=0, all pulses 0, busy=0.
REQ-030 a_raw 0->1 held before E0 -> busy high from E2, a=1 at E5, a_rise=1 for exactly the cycle after E5, busy=0 after E5.
REQ-031 b_raw high for 2 cycles then low (bounce) -> b stays 0, no b_rise, busy returns to 0, cnt back to 0.
REQ-032 a_raw and b_raw both 1->0 before the same edge (from a=b=1) -> a and b fall at the same edge, a_fall and b_fall both pulse one cycle.
REQ-033 a_raw 0->1, reset asserted one cycle at E3 while raw stays 1 -> no pulse at E5; a=1 at 5 edges after reset deassert edge, with a_rise.
REQ-034 Alternating a_raw every 3 cycles for 30 cycles -> a constant, zero pulses, cnt never exceeds 3.
